// File: rtl/seq_det_pkg.sv
// Shared constants and encodings for the serial pattern detector.
package seq_det_pkg;

    // Pattern loaded at reset for the default 4-bit configuration.
    localparam logic [3:0] DEF_PAT_C = 4'b1011;

    // Legal pattern length range.
    localparam int unsigned PAT_W_MIN = 2;
    localparam int unsigned PAT_W_MAX = 16;

    // Encodings for the overlap pin.
    typedef enum logic {
        NON_OVERLAP = 1'b0,
        OVERLAP     = 1'b1
    } overlap_e;

    // Detector FSM: FILL while fewer than PAT_W bits are in the window.
    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a same-cycle increment wins over clear.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    // Count register: reset, clear (to 1 on simultaneous increment), or saturating increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? W'(1) : '0;
        end else if (inc && !sat) begin
            cnt <= cnt + W'(1);
        end
    end

    // Saturation flag decoded from the count.
    always_comb begin
        sat = &cnt;
    end

endmodule

// File: rtl/seq_det_moore.sv
// Moore serial pattern detector with runtime-loadable pattern and saturating match count.
module seq_det_moore
    import seq_det_pkg::*;
#(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PAT_C),
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_vld,
    input  logic             overlap,
    input  logic             pat_ld,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int unsigned     FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    fsm_state_e         state_q, state_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    // Only the newest PAT_W-1 history bits are stored: the oldest is shifted out
    // before it could ever take part in a comparison.
    logic [PAT_W-2:0]   hist_q, hist_d;
    logic               y_q, y_d;

    logic [PAT_W-1:0]   hist_n;
    logic [FILL_W-1:0]  fill_inc;
    logic               match;
    logic               cnt_inc;

    // State register: pattern, history window, fill level, FSM state and match flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            fill_q  <= '0;
            pat_q   <= DEF_PAT;
            hist_q  <= '0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            y_q     <= y_d;
        end
    end

    // Next-state logic: pattern load beats bit acceptance; idle cycles hold everything.
    always_comb begin
        hist_n   = {hist_q, in};
        fill_inc = (state_q == ARMED) ? fill_q : fill_q + FILL_W'(1);
        match    = (fill_inc == FILL_FULL) && (hist_n == pat_q);

        fill_d  = fill_q;
        pat_d   = pat_q;
        hist_d  = hist_q;
        y_d     = y_q;
        cnt_inc = 1'b0;

        if (pat_ld) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
            y_d    = 1'b0;
        end else if (in_vld) begin
            hist_d  = hist_n[PAT_W-2:0];
            y_d     = match;
            cnt_inc = match;
            fill_d  = (match && (overlap_e'(overlap) == NON_OVERLAP)) ? '0 : fill_inc;
        end

        state_d = (fill_d == FILL_FULL) ? ARMED : FILL;
    end

    // Output logic: the match flag is purely a function of registered state.
    always_comb begin
        y = y_q;
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );

endmodule

// File: tb/tb_seq_det_moore.sv
// Self-checking bench for seq_det_moore: directed scenarios followed by random traffic,
// all compared against a bit-history reference model.
module tb_seq_det_moore;

    localparam int unsigned PAT_W   = 4;
    localparam int unsigned CNT_W   = 2;
    localparam logic [3:0]  DEF_PAT = 4'b1011;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             din = 1'b0;
    logic             in_vld = 1'b0;
    logic             overlap = 1'b1;
    logic             pat_ld = 1'b0;
    logic [PAT_W-1:0] pat_in = '0;
    logic             cnt_clr = 1'b0;
    logic             y;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: accepted bits since last reset/load, bits since the window last restarted.
    bit          m_bits[$];
    int unsigned m_win;
    logic [3:0]  m_pat;
    logic        m_y;
    int unsigned m_cnt;

    seq_det_moore #(
        .PAT_W   (PAT_W),
        .DEF_PAT (DEF_PAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (din),
        .in_vld    (in_vld),
        .overlap   (overlap),
        .pat_ld    (pat_ld),
        .pat_in    (pat_in),
        .cnt_clr   (cnt_clr),
        .y         (y),
        .match_cnt (match_cnt),
        .cnt_sat   (cnt_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit         hit;
        logic [3:0] last;
        hit = 1'b0;
        if (rst) begin
            m_bits.delete();
            m_win = 0;
            m_pat = DEF_PAT;
            m_y   = 1'b0;
            m_cnt = 0;
            return;
        end
        if (pat_ld) begin
            m_pat = pat_in;
            m_bits.delete();
            m_win = 0;
            m_y   = 1'b0;
        end else if (in_vld) begin
            m_bits.push_back(din);
            if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
            m_win++;
            if (m_win >= PAT_W) begin
                last = '0;
                for (int unsigned i = 0; i < PAT_W; i++)
                    last = {last[2:0], m_bits[m_bits.size() - PAT_W + i]};
                hit = (last == m_pat);
            end
            if (m_win > PAT_W) m_win = PAT_W;
            m_y = hit;
            if (hit && !overlap) m_win = 0;
        end
        if (cnt_clr)
            m_cnt = hit ? 1 : 0;
        else if (hit && m_cnt < CNT_MAX)
            m_cnt++;
    endtask

    // One clock: drive inputs, advance model at the edge, check outputs just after.
    task automatic step(input logic r, input logic v, input logic b, input logic ov,
                        input logic ld, input logic [3:0] p, input logic clr);
        rst = r; in_vld = v; din = b; overlap = ov; pat_ld = ld; pat_in = p; cnt_clr = clr;
        @(posedge clk);
        model_update();
        #1;
        chk("y", 32'(y), 32'(m_y));
        chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
        chk("cnt_sat", 32'(cnt_sat), 32'(m_cnt == CNT_MAX));
    endtask

    task automatic bit_in(input logic b, input logic ov);
        step(1'b0, 1'b1, b, ov, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, overlap, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        @(posedge clk); #1;

        // 1: reset state, then a single 1011 match
        do_reset();
        chk("reset_y", 32'(y), 32'd0);
        chk("reset_cnt", 32'(match_cnt), 32'd0);
        bit_in(1, 1); bit_in(0, 1); bit_in(1, 1);
        chk("t1_no_early", 32'(y), 32'd0);
        bit_in(1, 1);
        chk("t1_y", 32'(y), 32'd1);
        chk("t1_cnt", 32'(match_cnt), 32'd1);

        // 2: overlapping 1011011 gives two matches, non-overlapping gives one
        do_reset();
        foreach (DEF_PAT[i]) bit_in(DEF_PAT[i], 1);
        bit_in(0, 1); bit_in(1, 1); bit_in(1, 1);
        chk("t2_ov_cnt", 32'(match_cnt), 32'd2);
        do_reset();
        foreach (DEF_PAT[i]) bit_in(DEF_PAT[i], 0);
        bit_in(0, 0); bit_in(1, 0); bit_in(1, 0);
        chk("t2_nov_cnt", 32'(match_cnt), 32'd1);
        chk("t2_nov_y", 32'(y), 32'd0);

        // 3: idle gaps between bits; y holds across idles after the match
        do_reset();
        foreach (DEF_PAT[i]) begin bit_in(DEF_PAT[i], 1); idle(3); end
        chk("t3_hold_y", 32'(y), 32'd1);
        bit_in(0, 1);
        chk("t3_drop_y", 32'(y), 32'd0);

        // 4: pattern load drops the coincident bit and clears history
        do_reset();
        bit_in(1, 1); bit_in(1, 1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b0);
        bit_in(1, 1); bit_in(1, 1); bit_in(1, 1);
        chk("t4_no_match", 32'(y), 32'd0);
        bit_in(1, 1);
        chk("t4_match", 32'(y), 32'd1);

        // 5: saturation at CNT_W=2, then clear coincident with a match
        do_reset();
        for (int unsigned k = 0; k < 4; k++) foreach (DEF_PAT[i]) bit_in(DEF_PAT[i], 0);
        chk("t5_sat_cnt", 32'(match_cnt), 32'd3);
        chk("t5_sat", 32'(cnt_sat), 32'd1);
        bit_in(1, 0); bit_in(0, 0); bit_in(1, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
        chk("t5_clr_cnt", 32'(match_cnt), 32'd1);
        chk("t5_clr_sat", 32'(cnt_sat), 32'd0);

        // 6: reset while y=1 restores default pattern and discards history
        do_reset();
        foreach (DEF_PAT[i]) bit_in(DEF_PAT[i], 1);
        bit_in(0, 1); bit_in(1, 1); bit_in(1, 1);
        do_reset();
        chk("t6_y", 32'(y), 32'd0);
        chk("t6_cnt", 32'(match_cnt), 32'd0);
        bit_in(0, 1); bit_in(1, 1); bit_in(1, 1);
        chk("t6_no_match", 32'(y), 32'd0);

        // Random traffic against the model
        do_reset();
        for (int unsigned n = 0; n < 1500; n++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom),
                 ($urandom_range(0, 15) == 0) ? ~overlap : overlap,
                 ($urandom_range(0, 39) == 0),
                 4'($urandom),
                 ($urandom_range(0, 19) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
